// File: rtl/dac_wave_gen.sv
// DDS waveform generator for the parallel DAC: phase accumulator, wave shaper,
// amplitude/offset stage. New config is applied at the accumulator wrap.
module dac_wave_gen #(
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_ftw,
  input  logic [1:0]         cfg_wave,
  input  logic [DATA_W-1:0]  cfg_amp,
  input  logic [DATA_W-1:0]  cfg_offset,
  output logic [DATA_W-1:0]  dac_data,
  output logic               dac_valid,
  output logic               phase_wrap
);

  localparam int PW = 2 * DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } state_t;

  state_t state, state_nx;

  logic [PHASE_W-1:0] acc, acc_nx;
  logic [PHASE_W:0]   sum;
  logic               fire;
  logic               ld_cfg, ld_sh, apply, wrap_nx;

  logic [PHASE_W-1:0] ftw_a, ftw_s;
  logic [1:0]         wave_a, wave_s;
  logic [DATA_W-1:0]  amp_a, amp_s;
  logic [DATA_W-1:0]  off_a, off_s;

  logic [DATA_W-1:0]  p1, a1, o1;
  logic [1:0]         w1;
  logic               v1;
  logic [DATA_W-1:0]  raw;
  logic [DATA_W-1:0]  r2, a2, o2;
  logic               v2;
  logic [PW-1:0]      prod, tot;
  logic [DATA_W-1:0]  sat;

  assign cfg_ready = (state != PEND);
  assign fire      = cfg_valid & cfg_ready;
  assign sum       = {1'b0, acc} + {1'b0, ftw_a};

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    ld_cfg   = 1'b0;
    ld_sh    = 1'b0;
    apply    = 1'b0;
    wrap_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        acc_nx = '0;
        ld_cfg = fire;
        if (en) state_nx = RUN;
      end
      RUN: begin
        if (!en) begin
          state_nx = IDLE;
          acc_nx   = '0;
          ld_cfg   = fire;
        end else begin
          acc_nx  = sum[PHASE_W-1:0];
          wrap_nx = sum[PHASE_W];
          if (fire) begin
            ld_sh    = 1'b1;
            state_nx = PEND;
          end
        end
      end
      PEND: begin
        if (!en) begin
          state_nx = IDLE;
          acc_nx   = '0;
          apply    = 1'b1;
        end else begin
          acc_nx  = sum[PHASE_W-1:0];
          wrap_nx = sum[PHASE_W];
          // a stalled accumulator never wraps, so apply at once
          if (sum[PHASE_W] || ftw_a == '0) begin
            apply    = 1'b1;
            state_nx = RUN;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      phase_wrap <= 1'b0;
    end else begin
      state      <= state_nx;
      acc        <= acc_nx;
      phase_wrap <= wrap_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_a  <= '0;
      wave_a <= '0;
      amp_a  <= '0;
      off_a  <= '0;
      ftw_s  <= '0;
      wave_s <= '0;
      amp_s  <= '0;
      off_s  <= '0;
    end else begin
      if (ld_cfg) begin
        ftw_a  <= cfg_ftw;
        wave_a <= cfg_wave;
        amp_a  <= cfg_amp;
        off_a  <= cfg_offset;
      end else if (apply) begin
        ftw_a  <= ftw_s;
        wave_a <= wave_s;
        amp_a  <= amp_s;
        off_a  <= off_s;
      end
      if (ld_sh) begin
        ftw_s  <= cfg_ftw;
        wave_s <= cfg_wave;
        amp_s  <= cfg_amp;
        off_s  <= cfg_offset;
      end
    end
  end

  always_comb begin
    raw = '0;
    unique case (w1)
      2'd0: raw = '1;
      2'd1: raw = p1[DATA_W-1] ? '1 : '0;
      2'd2: raw = p1;
      2'd3: raw = p1[DATA_W-1] ? ~{p1[DATA_W-2:0], 1'b0}
                               : {p1[DATA_W-2:0], 1'b0};
      default: raw = '0;
    endcase
  end

  assign prod = PW'(r2) * (PW'(a2) + PW'(1));
  assign tot  = (prod >> DATA_W) + PW'(o2);
  assign sat  = (tot > PW'({DATA_W{1'b1}})) ? '1 : tot[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1        <= '0;
      w1        <= '0;
      a1        <= '0;
      o1        <= '0;
      v1        <= 1'b0;
      r2        <= '0;
      a2        <= '0;
      o2        <= '0;
      v2        <= 1'b0;
      dac_data  <= '0;
      dac_valid <= 1'b0;
    end else begin
      p1        <= acc[PHASE_W-1 -: DATA_W];
      w1        <= wave_a;
      a1        <= amp_a;
      o1        <= off_a;
      v1        <= (state != IDLE);
      r2        <= raw;
      a2        <= a1;
      o2        <= o1;
      v2        <= v1;
      dac_data  <= v2 ? sat : o2;
      dac_valid <= v2;
    end
  end

endmodule
